// File: rtl/seg_scroll_driver.sv
// seg_scroll_driver: N-digit multiplexed 7-segment driver with a writable hex buffer and hardware scrolling.
// Optional macro SEG_DIMMING_EN adds a 4-bit PWM brightness input.
module seg_scroll_driver #(
  parameter int NUM_DIGITS    = 8,
  parameter int MSG_LEN       = 16,
  parameter int SLOT_CYCLES   = 1000,
  parameter int BLANK_CYCLES  = 16,
  parameter int SCROLL_FRAMES = 64,
  localparam int AW = MSG_LEN > 1 ? $clog2(MSG_LEN) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  msg_wr_en,
  input  logic [AW-1:0]         msg_wr_addr,
  input  logic [3:0]            msg_wr_data,
  input  logic                  scroll_en,
  input  logic                  scroll_dir,
`ifdef SEG_DIMMING_EN
  input  logic [3:0]            brightness,
`endif
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_done,
  output logic [AW-1:0]         ptr
);
  localparam int DW = $clog2(NUM_DIGITS);
  localparam int SW = SLOT_CYCLES > 1 ? $clog2(SLOT_CYCLES) : 1;
  localparam int FW = SCROLL_FRAMES > 1 ? $clog2(SCROLL_FRAMES) : 1;

  logic [SW-1:0]         slot_q, slot_d;
  logic [DW-1:0]         dig_q, dig_d;
  logic [FW-1:0]         frm_q, frm_d;
  logic [AW-1:0]         ptr_q, ptr_d;
  logic [3:0]            buf_q [MSG_LEN];
  logic [3:0]            buf_d [MSG_LEN];
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic [3:0]            pwm_q, pwm_d;
  logic                  last_slot, step, act, lit;
  logic [AW:0]           sum;
  logic [AW-1:0]         rd_idx;

  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  always_comb begin
    last_slot  = slot_q == SW'(SLOT_CYCLES - 1);
    frame_done = last_slot && dig_q == '0;
    slot_d     = last_slot ? '0 : slot_q + SW'(1);
    dig_d      = !last_slot ? dig_q : dig_q == '0 ? DW'(NUM_DIGITS - 1) : dig_q - DW'(1);
    step       = frame_done && scroll_en && frm_q == FW'(SCROLL_FRAMES - 1);
    frm_d      = !(frame_done && scroll_en) ? frm_q : step ? '0 : frm_q + FW'(1);
    ptr_d      = !step ? ptr_q :
                 scroll_dir ? (ptr_q == '0 ? AW'(MSG_LEN - 1) : ptr_q - AW'(1)) :
                 (ptr_q == AW'(MSG_LEN - 1) ? '0 : ptr_q + AW'(1));
    // Window offset never exceeds MSG_LEN, so one conditional subtract wraps it.
    sum        = {1'b0, ptr_q} + (AW+1)'(NUM_DIGITS - 1) - (AW+1)'(dig_q);
    rd_idx     = sum >= (AW+1)'(MSG_LEN) ? AW'(sum - (AW+1)'(MSG_LEN)) : AW'(sum);
    pwm_d      = pwm_q + 4'd1;
    act        = slot_q >= SW'(BLANK_CYCLES);
`ifdef SEG_DIMMING_EN
    lit        = act && pwm_q < brightness;
`else
    lit        = act;
`endif
    an_d       = lit ? ~(NUM_DIGITS'(1) << dig_q) : '1;
    seg_d      = act ? hex7(buf_q[rd_idx]) : 7'h7F;
    buf_d      = buf_q;
    if (msg_wr_en && msg_wr_addr <= AW'(MSG_LEN - 1)) buf_d[msg_wr_addr] = msg_wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_q <= '0;
      dig_q  <= DW'(NUM_DIGITS - 1);
      frm_q  <= '0;
      ptr_q  <= '0;
      buf_q  <= '{default: '0};
      an_q   <= '1;
      seg_q  <= 7'h7F;
      pwm_q  <= '0;
    end else begin
      slot_q <= slot_d;
      dig_q  <= dig_d;
      frm_q  <= frm_d;
      ptr_q  <= ptr_d;
      buf_q  <= buf_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      pwm_q  <= pwm_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;
  assign ptr = ptr_q;
endmodule

// File: tb/tb_seg_scroll_driver.sv
// tb_seg_scroll_driver: directed checks of scanning, decoding, scrolling, writes and reset for seg_scroll_driver.
module tb_seg_scroll_driver;
  logic clk = 0, reset = 0;
  always #5 clk = ~clk;

  logic       wr_en = 0, scroll_en = 0, scroll_dir = 0;
  logic [3:0] wr_addr = 0, wr_data = 0;
  logic [3:0] an, ptr;
  logic [6:0] seg;
  logic       dp, frame_done;

  logic       u2_wr_en = 0, u2_scroll_en = 0, u2_scroll_dir = 0;
  logic [3:0] u2_wr_addr = 0, u2_wr_data = 0;
  logic [3:0] u2_an, u2_ptr;
  logic [6:0] u2_seg;
  logic       u2_dp, u2_frame_done;
`ifdef SEG_DIMMING_EN
  logic [3:0] brightness = 4'd15;
`endif

  int tests = 0, fails = 0;

  seg_scroll_driver #(.NUM_DIGITS(4), .MSG_LEN(16), .SLOT_CYCLES(20), .BLANK_CYCLES(4), .SCROLL_FRAMES(2)) dut (
    .clk(clk), .reset(reset), .msg_wr_en(wr_en), .msg_wr_addr(wr_addr), .msg_wr_data(wr_data),
    .scroll_en(scroll_en), .scroll_dir(scroll_dir),
`ifdef SEG_DIMMING_EN
    .brightness(brightness),
`endif
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done), .ptr(ptr));

  seg_scroll_driver #(.NUM_DIGITS(4), .MSG_LEN(12), .SLOT_CYCLES(20), .BLANK_CYCLES(4), .SCROLL_FRAMES(2)) u2 (
    .clk(clk), .reset(reset), .msg_wr_en(u2_wr_en), .msg_wr_addr(u2_wr_addr), .msg_wr_data(u2_wr_data),
    .scroll_en(u2_scroll_en), .scroll_dir(u2_scroll_dir),
`ifdef SEG_DIMMING_EN
    .brightness(brightness),
`endif
    .an(u2_an), .seg(u2_seg), .dp(u2_dp), .frame_done(u2_frame_done), .ptr(u2_ptr));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic show(input int k, input logic [6:0] exp, input string tag);
    logic [3:0] pat;
    int t = 0;
    pat = ~(4'b0001 << k);
    while (an !== pat && t < 400) begin tick(1); t++; end
    check({tag, "_an"}, an, pat);
    check(tag, seg, exp);
  endtask

  task automatic wait_ptr(input logic [3:0] exp, input int budget, input string tag);
    int t = 0;
    while (ptr !== exp && t < budget) begin tick(1); t++; end
    check(tag, ptr, exp);
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    tick(1);
    wr_en = 0;
  endtask

  initial begin
    int msg [16] = '{0, 3, 6, 0, 4, 10, 11, 12, 0, 0, 12, 10, 15, 14, 2, 1};
    int n, bad, lit;
    logic [6:0] e;
    #12;
    check("rst_an", an, 4'hF);
    check("rst_seg", seg, 7'h7F);
    check("rst_dp", dp, 1'b1);
    check("rst_fd", frame_done, 1'b0);
    check("rst_ptr", ptr, 4'h0);
    @(posedge clk); #1;
    reset = 1;
    for (int c = 1; c <= 20; c++) begin
      tick(1);
      check($sformatf("scan_an_c%0d", c), an, c <= 4 ? 4'hF : 4'b0111);
      if (c == 5) check("scan_seg0", seg, 7'h40);
    end
    tick(58); check("fd_c78", frame_done, 1'b0);
    tick(1);  check("fd_c79", frame_done, 1'b1);
    tick(1);  check("fd_c80", frame_done, 1'b0);
    tick(79); check("fd_c159", frame_done, 1'b1);

    for (int i = 0; i < 16; i++) wr(4'(i), 4'(msg[i]));
    show(3, 7'h40, "msg_d3");
    show(2, 7'h30, "msg_d2");
    show(1, 7'h02, "msg_d1");
    show(0, 7'h40, "msg_d0");
    check("noscroll_ptr", ptr, 4'h0);

    scroll_en = 1;
    wait_ptr(4'd1, 400, "scroll_p1");
    n = 0;
    while (ptr !== 4'd2 && n < 400) begin tick(1); n++; end
    check("step_period", n, 160);
    show(3, 7'h02, "p2_left");
    wait_ptr(4'd14, 2200, "scroll_p14");
    show(3, 7'h24, "p14_left");
    show(0, 7'h30, "p14_right");
    wait_ptr(4'd15, 400, "scroll_p15");
    wait_ptr(4'd0, 400, "wrap_p0");
    scroll_dir = 1;
    check("dir_hold", ptr, 4'd0);
    wait_ptr(4'd15, 400, "dir1_p15");
    scroll_en = 0;
    tick(400);
    check("freeze_ptr", ptr, 4'd15);

    show(1, 7'h30, "pre_wr");
    wr(4'd1, 4'd8);
    check("wr_same_cycle_old", seg, 7'h30);
    tick(1);
    check("wr_new_seg", seg, 7'h00);
    check("wr_new_an", an, 4'b1101);

    for (int a = 12; a < 16; a++) begin
      u2_wr_en = 1; u2_wr_addr = 4'(a); u2_wr_data = 4'd8;
      tick(1);
    end
    u2_wr_addr = 4'd3;
    tick(1);
    u2_wr_en = 0;
    bad = 0; lit = 0;
    for (int c = 0; c < 80; c++) begin
      tick(1);
      if (u2_an !== 4'hF) begin
        lit++;
        e = (u2_an === 4'b1110) ? 7'h00 : 7'h40;
        if (u2_seg !== e) bad++;
      end
    end
    check("u2_oor_bad", bad, 0);
    check("u2_lit", lit, 64);
    check("u2_ptr", u2_ptr, 4'd0);

    show(2, 7'h40, "pre_rst");
    tick(3); #2;
    reset = 0;
    #1;
    check("mid_rst_an", an, 4'hF);
    check("mid_rst_seg", seg, 7'h7F);
    check("mid_rst_ptr", ptr, 4'd0);
    check("mid_rst_fd", frame_done, 1'b0);
    @(posedge clk); #1;
    reset = 1;
    for (int c = 1; c <= 5; c++) begin
      tick(1);
      check($sformatf("rescan_an_c%0d", c), an, c <= 4 ? 4'hF : 4'b0111);
    end
    show(2, 7'h40, "clr_buf1");
    show(1, 7'h40, "clr_buf2");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
